// File: rtl/pll_reset_sequencer_if.sv
// Lock input and reset/status outputs of the PLL reset sequencer.
// The sequencer side is the master; the board/core side is the slave.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       core_rst_n;
    logic [1:0] state;
    logic [7:0] relock_cnt;
    logic       timeout_err;

    modport master (
        input  pll_locked,
        output pll_rst, core_rst_n, state, relock_cnt, timeout_err
    );
    modport slave (
        output pll_locked,
        input  pll_rst, core_rst_n, state, relock_cnt, timeout_err
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Sequences the PLL reset pulse, qualifies a debounced lock and releases core reset.
// It restarts the PLL on loss of lock or lock timeout.
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int SYNC_STAGES      = 2,
    parameter int CNT_W            = 17
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_reset_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);

    state_t                 st, st_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   lk;
    logic                   to_hit, lost;
    logic                   pll_rst_q, core_rst_n_q, to_q;
    logic [7:0]             relock_q;

    assign lk = sync_pipe[SYNC_STAGES-1];

    // Lock is meaningless while the PLL is held in reset, so stale samples are
    // flushed there and qualification always starts from a fresh synchronizer.
    always_ff @(posedge refclk) begin
        if (!rst_n || st == RESET_PLL)
            sync_pipe <= '0;
        else
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], bus.pll_locked};
    end

    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        to_hit  = 1'b0;
        lost    = 1'b0;
        case (st)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    cnt_nxt = '0;
                    st_nxt  = WAIT_LOCK;
                end else cnt_nxt = cnt + CNT_W'(1);
            end
            WAIT_LOCK: begin
                if (lk) begin
                    cnt_nxt = '0;
                    st_nxt  = STABLE;
                end else if (cnt == TO_LAST) begin
                    to_hit  = 1'b1;
                    cnt_nxt = '0;
                    st_nxt  = RESET_PLL;
                end else cnt_nxt = cnt + CNT_W'(1);
            end
            STABLE: begin
                if (!lk) begin
                    cnt_nxt = '0;
                    st_nxt  = WAIT_LOCK;
                end else if (cnt == STB_LAST) begin
                    cnt_nxt = '0;
                    st_nxt  = RUN;
                end else cnt_nxt = cnt + CNT_W'(1);
            end
            RUN: begin
                if (!lk) begin
                    lost    = 1'b1;
                    cnt_nxt = '0;
                    st_nxt  = RESET_PLL;
                end
            end
            default: begin
                cnt_nxt = '0;
                st_nxt  = RESET_PLL;
            end
        endcase
    end

    // Reset outputs are decoded from the next state so they move on the same
    // edge as the state register.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            st           <= RESET_PLL;
            cnt          <= '0;
            pll_rst_q    <= 1'b1;
            core_rst_n_q <= 1'b0;
            to_q         <= 1'b0;
            relock_q     <= 8'd0;
        end else begin
            st           <= st_nxt;
            cnt          <= cnt_nxt;
            pll_rst_q    <= (st_nxt == RESET_PLL);
            core_rst_n_q <= (st_nxt == RUN);
            to_q         <= to_hit;
            if (lost && relock_q != 8'hFF)
                relock_q <= relock_q + 8'd1;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.core_rst_n  = core_rst_n_q;
    assign bus.state       = st;
    assign bus.relock_cnt  = relock_q;
    assign bus.timeout_err = to_q;
endmodule
